// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of the pipelined MIPS core. It owns the PC and
//   drives a synchronous instruction memory with a 1-cycle read latency. It
//   presents the IF/ID payload (instr, pc, pc+4, valid) to decode.
//
//   Ports
//     clk, rst        single clock, synchronous active-high reset
//     stall           hazard unit hold: payload and PC freeze
//     redirect_valid  taken branch/jump this cycle; beats stall
//     redirect_pc     redirect target (low two bits are dropped)
//     imem_addr       combinational read address to instruction memory
//     imem_rdata      word for the address presented last cycle
//     ifid_instr/pc/pc4/valid  payload to decode
//     addr_err        sticky flag for a misaligned redirect target
//     fetch_count     number of fetches issued (wraps)
// ----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic              ifid_valid,
  output logic              addr_err,
  output logic [31:0]       fetch_count
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  // pc:     next address to fetch
  // req_pc: address whose data is currently on imem_rdata
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              req_valid;
    logic              addr_err;
    logic [31:0]       fetch_count;
  } fetch_state_t;

  fetch_state_t st_q, st_d;

  logic [ADDR_W-1:0] tgt;
  logic              misaligned;

  assign tgt        = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign misaligned = |redirect_pc[1:0];

  // Read address. A stall re-reads the address already in flight so the
  // memory keeps returning the same word while decode is held.
  always_comb begin
    imem_addr = st_q.pc;
    if (rst)                 imem_addr = RESET_PC;
    else if (redirect_valid) imem_addr = tgt;
    else if (stall)          imem_addr = st_q.req_pc;
  end

  // Next state: redirect > stall > sequential fetch.
  always_comb begin
    st_d = st_q;
    if (redirect_valid) begin
      st_d.req_pc      = tgt;
      st_d.pc          = tgt + PC_STEP;
      st_d.req_valid   = 1'b1;
      st_d.fetch_count = st_q.fetch_count + 32'd1;
      st_d.addr_err    = st_q.addr_err | misaligned;
    end else if (!stall) begin
      st_d.req_pc      = st_q.pc;
      st_d.pc          = st_q.pc + PC_STEP;
      st_d.req_valid   = 1'b1;
      st_d.fetch_count = st_q.fetch_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= '{pc: RESET_PC, req_pc: RESET_PC, req_valid: 1'b0,
                addr_err: 1'b0, fetch_count: 32'd0};
    end else begin
      st_q <= st_d;
    end
  end

  // Payload. The word on imem_rdata belongs to the path being abandoned
  // when a redirect arrives, so it is squashed in the same cycle. Reset
  // forces the documented idle values even before the first clock edge.
  assign ifid_instr  = imem_rdata;
  assign ifid_pc     = rst ? RESET_PC : st_q.req_pc;
  assign ifid_pc4    = ifid_pc + PC_STEP;
  assign ifid_valid  = st_q.req_valid & ~redirect_valid & ~rst;
  assign addr_err    = st_q.addr_err & ~rst;
  assign fetch_count = rst ? 32'd0 : st_q.fetch_count;

endmodule
